// File: rtl/bcd_scan_display.sv
// Three-digit multiplexed common-anode 7-segment driver fed by a BCD converter.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_display #(
   parameter int DIV_CYCLES = 50000,
   parameter int CNT_W      = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] units,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       pending,
   output logic       frame_done
);

   typedef enum logic [1:0] {S_U, S_T, S_H} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_pend_h, r_pend_t, r_pend_u;
   logic [3:0]       r_act_h, r_act_t, r_act_u;
   logic             r_pending, r_frame_done;
   logic [6:0]       r_seg;
   logic [2:0]       r_an;

   logic             w_tc, w_frame, w_blank_t, w_blank_h;
   state_t           w_state_nx;
   logic [3:0]       w_act_h_nx, w_act_t_nx, w_act_u_nx;
   logic [6:0]       w_seg_nx;
   logic [2:0]       w_an_nx;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      case (d)
         4'd0:    f_decode = 7'h40;
         4'd1:    f_decode = 7'h79;
         4'd2:    f_decode = 7'h24;
         4'd3:    f_decode = 7'h30;
         4'd4:    f_decode = 7'h19;
         4'd5:    f_decode = 7'h12;
         4'd6:    f_decode = 7'h02;
         4'd7:    f_decode = 7'h78;
         4'd8:    f_decode = 7'h00;
         4'd9:    f_decode = 7'h10;
         default: f_decode = 7'h3F;
      endcase
   endfunction

   // Outputs are registered from next-state values so a new slot shows on the edge it begins.
   always_comb begin
      w_tc       = (r_cnt == CNT_W'(DIV_CYCLES - 1));
      w_frame    = w_tc && (r_state == S_H);
      w_state_nx = r_state;
      if (w_tc) begin
         case (r_state)
            S_U:     w_state_nx = S_T;
            S_T:     w_state_nx = S_H;
            default: w_state_nx = S_U;
         endcase
      end

      w_act_h_nx = r_act_h;
      w_act_t_nx = r_act_t;
      w_act_u_nx = r_act_u;
      if (w_frame && load) begin
         w_act_h_nx = hundreds;
         w_act_t_nx = tens;
         w_act_u_nx = units;
      end else if (w_frame && r_pending) begin
         w_act_h_nx = r_pend_h;
         w_act_t_nx = r_pend_t;
         w_act_u_nx = r_pend_u;
      end

`ifdef BCD_SCAN_LZB_EN
      w_blank_h = (w_act_h_nx == 4'd0);
      w_blank_t = (w_act_h_nx == 4'd0) && (w_act_t_nx == 4'd0);
`else
      w_blank_h = 1'b0;
      w_blank_t = 1'b0;
`endif

      case (w_state_nx)
         S_T: begin
            w_an_nx  = 3'b101;
            w_seg_nx = w_blank_t ? 7'h7F : f_decode(w_act_t_nx);
         end
         S_H: begin
            w_an_nx  = 3'b011;
            w_seg_nx = w_blank_h ? 7'h7F : f_decode(w_act_h_nx);
         end
         default: begin
            w_an_nx  = 3'b110;
            w_seg_nx = f_decode(w_act_u_nx);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_U;
         r_cnt        <= '0;
         r_pend_h     <= 4'd0;
         r_pend_t     <= 4'd0;
         r_pend_u     <= 4'd0;
         r_act_h      <= 4'd0;
         r_act_t      <= 4'd0;
         r_act_u      <= 4'd0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
         r_seg        <= 7'h7F;
         r_an         <= 3'b111;
      end else begin
         r_cnt        <= w_tc ? '0 : r_cnt + CNT_W'(1);
         r_state      <= w_state_nx;
         r_act_h      <= w_act_h_nx;
         r_act_t      <= w_act_t_nx;
         r_act_u      <= w_act_u_nx;
         r_frame_done <= w_frame;
         r_seg        <= w_seg_nx;
         r_an         <= w_an_nx;
         // A load on the boundary bypasses pending, so the flag clears either way.
         if (w_frame) begin
            r_pending <= 1'b0;
         end else if (load) begin
            r_pend_h  <= hundreds;
            r_pend_t  <= tens;
            r_pend_u  <= units;
            r_pending <= 1'b1;
         end
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign pending    = r_pending;
   assign frame_done = r_frame_done;

endmodule
